// File: rtl/prelab5_pkg.sv
// Shared definitions for the prelab5 pause/count slice: FSM state encodings
// and the enable constants used by the downstream toggle FSM.
package prelab5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    localparam logic ENABLED  = 1'b1;
    localparam logic DISABLED = 1'b0;

endpackage

// File: rtl/prelab5_tick_gen.sv
// Free-running divider producing a one-cycle debounce sample tick every
// CLK_DIV clock cycles (tick is high while the count sits at CLK_DIV-1).
module prelab5_tick_gen #(
    parameter int unsigned CLK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prelab5_btn_cond.sv
// Push-button conditioner: synchronizer, tick-sampled debounce, press FSM and
// single-cycle press/long-press pulses. Long press is built only when
// PRELAB5_LONG_PRESS_EN is defined; otherwise pb_long is tied low.
module prelab5_btn_cond
    import prelab5_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 100000,
    parameter int unsigned DB_DEPTH   = 4,
    parameter int unsigned LONG_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_in,
    output logic pb_level,
    output logic pb_pulse,
    output logic pb_long
);

    logic                r_sync1;
    logic                r_sync2;
    logic                w_tick;
    logic [DB_DEPTH-1:0] r_shift;
    logic                r_level;
    logic                r_pulse;
    logic                w_rise;
    logic                w_fall;
    state_t              r_state;

    prelab5_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (w_tick)
    );

    assign w_rise = (&r_shift) & ~r_level;
    assign w_fall = ~(|r_shift) & r_level;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_shift <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= pb_in;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_shift <= {r_shift[DB_DEPTH-2:0], r_sync2};
            end
            if (w_rise) begin
                r_level <= 1'b1;
            end else if (w_fall) begin
                r_level <= 1'b0;
            end
            // Pulse lands on the same edge that raises the level.
            r_pulse <= w_rise;
        end
    end

`ifdef PRELAB5_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_TGT = HW'(LONG_TICKS);

    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_inc;
    logic          r_long;

    assign w_hold_inc = r_hold + 1'b1;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_long  <= 1'b0;
        end else begin
            r_long <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (r_level) begin
                        r_state <= ST_PRESSED;
                        r_hold  <= '0;
                    end
                end
                ST_PRESSED: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick && (r_hold != HOLD_TGT)) begin
                        // Counter stops at the target, so it can never wrap.
                        r_hold <= w_hold_inc;
                        if (w_hold_inc == HOLD_TGT) begin
                            r_state <= ST_LONG;
                            r_long  <= 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pb_long = r_long;
`else
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (r_level) begin
                        r_state <= ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    if (!r_level) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pb_long = 1'b0;
`endif

    assign pb_level = r_level;
    assign pb_pulse = r_pulse;

endmodule

// File: tb/tb_prelab5_btn_cond.sv
// Scoreboard bench for prelab5_btn_cond (CLK_DIV=4, DB_DEPTH=4, LONG_TICKS=8).
// Honours PRELAB5_LONG_PRESS_EN the same way as the design.
module tb_prelab5_btn_cond;

    localparam int C = 4;
    localparam int D = 4;
    localparam int L = 8;
`ifdef PRELAB5_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic pb_in = 1'b0;
    logic pb_level;
    logic pb_pulse;
    logic pb_long;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int pulse_cnt  = 0;
    int long_cnt   = 0;
    int level_cyc  = 0;
    int overlap    = 0;
    int last_pulse = 0;
    int last_long  = 0;
    bit tog        = 1'b0;

    logic [2:0] exp_q[$];

    prelab5_btn_cond #(
        .CLK_DIV   (C),
        .DB_DEPTH  (D),
        .LONG_TICKS(L)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pb_in   (pb_in),
        .pb_level(pb_level),
        .pb_pulse(pb_pulse),
        .pb_long (pb_long)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input integer act, input integer lo, input integer hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at cycle %0d", name, act, lo, hi, cyc);
        end
    endtask

    // Reference model: pb_s is pb_in two edges late, samples are taken every
    // C-th edge after reset, the level follows the last D samples when they
    // agree, and a long press is LONG_TICKS samples counted after the press.
    int  m_k;
    int  m_held;
    bit  m_level;
    bit  m_in_press;
    bit  m_long_done;
    bit  m_sync[$];
    bit  m_win[$];

    always @(posedge clk) begin
        bit tick, ps, lvl_prev, e_pulse, e_long;
        int ones;
        if (rst_n === 1'b1) begin
            m_k = 0; m_held = 0; m_level = 0; m_in_press = 0; m_long_done = 0;
            m_sync = '{0, 0};
            m_win.delete();
            for (int i = 0; i < D; i++) m_win.push_back(1'b0);
            exp_q.push_back(3'b000);
        end else begin
            tick = ((m_k % C) == C - 1);
            m_k++;
            ones = 0;
            foreach (m_win[i]) ones += m_win[i];
            ps = m_sync[0];
            m_sync.push_back(pb_in);
            void'(m_sync.pop_front());
            lvl_prev = m_level;
            if (ones == D) m_level = 1'b1;
            else if (ones == 0) m_level = 1'b0;
            if (tick) begin
                m_win.push_back(ps);
                void'(m_win.pop_front());
            end
            e_pulse = m_level && !lvl_prev;
            e_long  = 1'b0;
            if (!m_in_press) begin
                if (lvl_prev) begin
                    m_in_press = 1; m_held = 0; m_long_done = 0;
                end
            end else if (!lvl_prev) begin
                m_in_press = 0;
            end else if (LONG_EN && !m_long_done && tick) begin
                m_held++;
                if (m_held == L) begin
                    m_long_done = 1;
                    e_long = 1;
                end
            end
            exp_q.push_back({m_level, e_pulse, e_long});
        end
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs{level,pulse,long}", {pb_level, pb_pulse, pb_long}, e);
        end
        if (pb_pulse === 1'b1) begin
            pulse_cnt++;
            last_pulse = cyc;
            tog = ~tog;
        end
        if (pb_long === 1'b1) begin
            long_cnt++;
            last_long = cyc;
        end
        if (pb_level === 1'b1) level_cyc++;
        if (pb_pulse === 1'b1 && pb_long === 1'b1) overlap++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        pulse_cnt = 0;
        long_cnt  = 0;
        level_cyc = 0;
    endtask

    task automatic bounce(input int cycles, input bit first);
        int  left;
        bit  v;
        v = first;
        left = cycles;
        while (left > 0) begin
            int run;
            run = $urandom_range(1, 4);
            if (run > left) run = left;
            pb_in = v;
            step(run);
            left -= run;
            v = ~v;
        end
    endtask

    initial begin
        int rise;
        step(3);
        check("reset_outputs", {pb_level, pb_pulse, pb_long}, 0);
        rst_n = 1'b0;
        step(5);
        check("idle_outputs", {pb_level, pb_pulse, pb_long}, 0);

        // Clean press
        clear_counts();
        rise = cyc;
        pb_in = 1'b1;
        step(30);
        check("clean_pulse_count", pulse_cnt, 1);
        check_range("clean_latency", last_pulse - rise, 15, 19);
        check("clean_level", pb_level, 1);
        check("clean_long_count", long_cnt, 0);
        pb_in = 1'b0;
        step(30);
        check("clean_release_pulses", pulse_cnt, 1);
        check("clean_release_level", pb_level, 0);

        // Bounce on press, then stable, then bounce on release
        clear_counts();
        for (int i = 0; i < 40; i++) begin
            pb_in = ((i / 3) % 2) == 0;
            step(1);
        end
        bounce(40, 1'b1);
        check("bounce_no_pulse", pulse_cnt, 0);
        check("bounce_no_level", level_cyc, 0);
        rise = cyc;
        pb_in = 1'b1;
        step(30);
        check("bounce_stable_pulse", pulse_cnt, 1);
        check_range("bounce_latency", last_pulse - rise, 15, 19);
        bounce(40, 1'b0);
        pb_in = 1'b0;
        step(30);
        check("bounce_release_pulses", pulse_cnt, 1);
        check("bounce_release_level", pb_level, 0);

        // Long press
        clear_counts();
        pb_in = 1'b1;
        step(80);
        check("long_pulse_count", pulse_cnt, 1);
        check("long_long_count", long_cnt, LONG_EN ? 1 : 0);
        if (long_cnt == 1) check_range("long_latency", last_long - last_pulse, (L - 1) * C, (L + 1) * C);
        pb_in = 1'b0;
        step(30);
        check("long_release_long_count", long_cnt, LONG_EN ? 1 : 0);

        // Reset mid-press
        clear_counts();
        pb_in = 1'b1;
        step(10);
        rst_n = 1'b1;
        step(1);
        check("midreset_outputs", {pb_level, pb_pulse, pb_long}, 0);
        step(1);
        rst_n = 1'b0;
        rise = cyc;
        step(30);
        check("midreset_pulse_count", pulse_cnt, 1);
        check_range("midreset_latency", last_pulse - rise, 15, 19);
        pb_in = 1'b0;
        step(30);

        // Repeated presses driving the toggle FSM
        clear_counts();
        tog = 1'b0;
        for (int p = 0; p < 3; p++) begin
            pb_in = 1'b1;
            step(30);
            check("toggle_state", tog, (p + 1) % 2);
            pb_in = 1'b0;
            step(30);
        end
        check("repeat_pulse_count", pulse_cnt, 3);

        // Short glitch
        clear_counts();
        pb_in = 1'b1;
        step(6);
        pb_in = 1'b0;
        step(30);
        check("glitch_pulse_count", pulse_cnt, 0);
        check("glitch_level", level_cyc, 0);

        // Randomised bouncy presses of random length, checked by the model
        for (int r = 0; r < 20; r++) begin
            bounce($urandom_range(0, 20), 1'b1);
            pb_in = 1'b1;
            step($urandom_range(0, 60));
            bounce($urandom_range(0, 20), 1'b0);
            pb_in = 1'b0;
            step($urandom_range(0, 40));
        end
        pb_in = 1'b0;
        step(40);

        check("pulse_long_overlap", overlap, 0);
        check("scoreboard_drained", exp_q.size() <= 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
